pcbuf_pkt: RTL and testbench
============================

# pcbuf_pkt

Read side of the chip buffer: drains the 16-bit chip-data FIFO once it reports a full chip burst (`pcbuf_full`) and emits it downstream as a framed packet. Each packet carries a sync word, a tag word, a length word, N payload words and a checksum word, sent on a valid/ready stream. The block sits between the chip buffer and the uplink packet mux. It owns `pcbuf_rdreq` exclusively.

## Interface
- `SYNC_WORD`, 16'hEB90, first word of every packet
- `clk_sys`  in  1  system clock; one clock domain, all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `pkt_en`  in  1  1 = new packets may start; sampled only in IDLE
- `chip_len`  in  20  payload words per packet; only [11:0] used
- `chip_sel`  in  7  chip select, copied into the tag word
- `pcbuf_full`  in  1  buffer holds ≥ chip_len[11:0] words
- `pcbuf_empty`  in  1  buffer empty
- `pcbuf_rdreq`  out  1  FIFO read strobe; `pcbuf_q` is valid the cycle after
- `pcbuf_q`  in  16  FIFO read data
- `pkt_d`  out  16  stream data
- `pkt_vld`  out  1  stream valid
- `pkt_rdy`  in  1  stream ready; a word transfers when `pkt_vld & pkt_rdy`
- `pkt_sop`  out  1  qualifies the sync word
- `pkt_eop`  out  1  qualifies the checksum word
- `pkt_busy`  out  1  1 whenever state ≠ IDLE
- `pkt_cnt`  out  16  completed-packet count, wraps at 2^16

## Operation
- Reset values: every output is 0, `seq`=0, state=IDLE, skid buffer empty, all counters 0.
- States:
  - IDLE → SYNC when `pkt_en & pcbuf_full & chip_len[11:0]≠0`.
  - Entering SYNC latches `len=chip_len[11:0]` and `sel=chip_sel`. Later changes to the inputs do not affect the current packet.
  - SYNC → TAG → LEN → PAY → SUM → IDLE. Each header and trailer state advances on its word transfer. PAY advances once the N-th payload word transfers.
- Words:
  - SYNC: `SYNC_WORD`
  - TAG: {1'b0, sel, seq}
  - LEN: {4'h0, len}
  - PAY: buffer head
  - SUM: 16-bit sum, mod 2^16, of the N payload words transferred
- `pkt_vld` is 1 in SYNC, TAG, LEN and SUM. In PAY it is 1 only while the skid buffer is non-empty. `pkt_vld` and `pkt_d` have no combinational path from `pkt_rdy`.
- Skid buffer:
  - 2 entries. `rd_cnt` counts reads issued; `tx_cnt` counts payload words transferred.
  - Only PAY issues reads. `pcbuf_rdreq = (state==PAY) & (rd_cnt<len) & ~pcbuf_empty & (occ + inflight − pop < 2)`, where `pop` = payload transfer this cycle.
  - This rule never overflows the buffer and never over-reads past `len`.
- `pcbuf_empty` mid-payload: reads stall and `pkt_vld` drops when the buffer drains. Streaming resumes when data returns. No error is flagged.
- On SUM transfer: `seq` increments (255→0 wrap), `pkt_cnt` increments (wrap), checksum accumulator clears.
- `pkt_en` deasserted mid-packet: the packet completes; only new starts are blocked.
- `chip_len[11:0]=0`: never starts, even though `pcbuf_full` is then always 1.
- Reset mid-packet: immediate return to reset values. Words already read from the FIFO are discarded. FIFO contents are untouched.

## Timing
- Start condition true in IDLE at cycle t → SYNC valid with `pkt_sop` at t+1.
- Read latency: `rdreq` in cycle c → `pcbuf_q` captured at end of c+1 → visible on `pkt_d` in c+2.
- With `pkt_rdy` held 1 and data available:
  - SYNC t+1, TAG t+2, LEN t+3.
  - PAY entered at t+4 with `rdreq` high.
  - Payload word k appears at t+6+k. No bubbles.
  - SUM with `pkt_eop` at t+6+N.
  - IDLE at t+7+N, where the next start may be evaluated.
- Header, payload and trailer words hold stable while `pkt_vld & ~pkt_rdy`.
- `pkt_sop` and `pkt_eop` are single-word qualifiers, high only with `pkt_vld`.

## Test plan
- Basic packet: len=4, sel=5, FIFO 1,2,3,4, `pkt_rdy`=1 → 0xEB90, 0x0500, 0x0004, 1, 2, 3, 4, 0x000A. SUM at t+10; `pkt_cnt`=1; exactly 4 `rdreq` pulses.
- Backpressure: same data, `pkt_rdy` random 50% → identical word sequence, no drop or duplicate, never more than 2 reads outstanding beyond transferred words.
- Len zero: len=0, `pcbuf_full`=1, `pkt_en`=1 for 100 cycles → `pkt_busy`, `pkt_vld` and `rdreq` all stay 0.
- Checksum and seq wrap: 257 packets of len=2, data 0xFFFF, 0x0003 → every SUM=0x0002. TAG seq of packet 257 = 0x00. `pkt_cnt`=257.
- Mid-payload starvation: `pcbuf_empty` forced 1 for 5 cycles during PAY → `pkt_vld` drops after the buffer drains, resumes, and the final checksum is correct.
- Reset in PAY after 2 of 4 words → all outputs 0 next cycle. With the FIFO refilled, the next packet carries seq=0.

Source files
------------

// File: rtl/pcbuf_pkt.sv
// Drains a full chip burst from the 16-bit chip buffer and frames it as SYNC/TAG/LEN/payload/SUM on a valid/ready stream.
// Latency: start -> SYNC next cycle, first payload 2 cycles into PAY; stalls hold words, a 2-entry skid absorbs read latency.
module pcbuf_pkt #(
    parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        pkt_en,
    input  logic [19:0] chip_len,
    input  logic [6:0]  chip_sel,
    input  logic        pcbuf_full,
    input  logic        pcbuf_empty,
    output logic        pcbuf_rdreq,
    input  logic [15:0] pcbuf_q,
    output logic [15:0] pkt_d,
    output logic        pkt_vld,
    input  logic        pkt_rdy,
    output logic        pkt_sop,
    output logic        pkt_eop,
    output logic        pkt_busy,
    output logic [15:0] pkt_cnt
);

    typedef enum logic [2:0] {IDLE, SYNC, TAG, LEN, PAY, SUM} state_t;

    state_t      state;
    logic [11:0] len;
    logic [11:0] rd_cnt;
    logic [11:0] tx_cnt;
    logic [6:0]  sel;
    logic [7:0]  seq;
    logic [15:0] csum;
    logic [15:0] skid0;
    logic [15:0] skid1;
    logic [1:0]  occ;
    logic        inflight;
    logic        start;
    logic        xfer;
    logic        pop;
    logic        unused_len_hi;

    assign unused_len_hi = ^chip_len[19:12];

    assign start = pkt_en & pcbuf_full & (chip_len[11:0] != 12'd0);
    assign xfer  = pkt_vld & pkt_rdy;
    assign pop   = xfer & (state == PAY);

    // Words already in the skid plus the read in flight must leave room for the next read.
    assign pcbuf_rdreq = (state == PAY) & (rd_cnt < len) & ~pcbuf_empty &
                         (({1'b0, occ} + {2'b00, inflight}) < (3'd2 + {2'b00, pop}));

    assign pkt_sop  = (state == SYNC);
    assign pkt_eop  = (state == SUM);
    assign pkt_busy = (state != IDLE);

    always_comb begin
        pkt_vld = 1'b0;
        pkt_d   = 16'h0000;
        case (state)
            SYNC: begin
                pkt_vld = 1'b1;
                pkt_d   = SYNC_WORD;
            end
            TAG: begin
                pkt_vld = 1'b1;
                pkt_d   = {1'b0, sel, seq};
            end
            LEN: begin
                pkt_vld = 1'b1;
                pkt_d   = {4'h0, len};
            end
            PAY: begin
                pkt_vld = (occ != 2'd0);
                pkt_d   = skid0;
            end
            SUM: begin
                pkt_vld = 1'b1;
                pkt_d   = csum;
            end
            default: begin
                pkt_vld = 1'b0;
                pkt_d   = 16'h0000;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            len      <= 12'd0;
            rd_cnt   <= 12'd0;
            tx_cnt   <= 12'd0;
            sel      <= 7'd0;
            seq      <= 8'd0;
            csum     <= 16'h0000;
            skid0    <= 16'h0000;
            skid1    <= 16'h0000;
            occ      <= 2'd0;
            inflight <= 1'b0;
            pkt_cnt  <= 16'h0000;
        end else begin
            inflight <= pcbuf_rdreq;
            if (pcbuf_rdreq) begin
                rd_cnt <= rd_cnt + 12'd1;
            end

            // skid0 is always the head; occ never exceeds 2 so push+pop never sees occ==2.
            case ({inflight, pop})
                2'b10: begin
                    if (occ == 2'd0) skid0 <= pcbuf_q;
                    else             skid1 <= pcbuf_q;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    skid0 <= skid1;
                    occ   <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        skid0 <= pcbuf_q;
                    end else begin
                        skid0 <= skid1;
                        skid1 <= pcbuf_q;
                    end
                end
                default: ;
            endcase

            if (pop) begin
                csum   <= csum + skid0;
                tx_cnt <= tx_cnt + 12'd1;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state  <= SYNC;
                        len    <= chip_len[11:0];
                        sel    <= chip_sel;
                        rd_cnt <= 12'd0;
                        tx_cnt <= 12'd0;
                    end
                end
                SYNC: if (xfer) state <= TAG;
                TAG:  if (xfer) state <= LEN;
                LEN:  if (xfer) state <= PAY;
                PAY:  if (pop && (tx_cnt == len - 12'd1)) state <= SUM;
                SUM: begin
                    if (xfer) begin
                        state   <= IDLE;
                        seq     <= seq + 8'd1;
                        pkt_cnt <= pkt_cnt + 16'd1;
                        csum    <= 16'h0000;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcbuf_pkt.sv
// Scoreboard bench for pcbuf_pkt: a queue-backed FIFO model feeds the block, expected words are queued at packet start.
module tb_pcbuf_pkt;

    typedef struct packed {
        logic [15:0] d;
        logic        sop;
        logic        eop;
        logic        pay;
        logic        tag;
    } exp_t;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        pkt_en;
    logic [19:0] chip_len;
    logic [6:0]  chip_sel;
    logic        pcbuf_full;
    logic        pcbuf_empty;
    logic        pcbuf_rdreq;
    logic [15:0] pcbuf_q = 16'h0000;
    logic [15:0] pkt_d;
    logic        pkt_vld;
    logic        pkt_rdy;
    logic        pkt_sop;
    logic        pkt_eop;
    logic        pkt_busy;
    logic [15:0] pkt_cnt;

    int checks = 0;
    int errors = 0;

    logic [15:0] fifo[$];
    logic [15:0] pay_q[$];
    exp_t        exp_q[$];
    exp_t        mon_e;
    int          pushes = 0;
    int          pops = 0;
    int          rd_issued = 0;
    int          pay_tx = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          eop_cyc = 0;
    logic        force_empty = 1'b0;
    logic [7:0]  exp_seq = 8'd0;
    logic [15:0] last_tag = 16'h0000;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_d = 16'h0000;

    pcbuf_pkt dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .pkt_en      (pkt_en),
        .chip_len    (chip_len),
        .chip_sel    (chip_sel),
        .pcbuf_full  (pcbuf_full),
        .pcbuf_empty (pcbuf_empty),
        .pcbuf_rdreq (pcbuf_rdreq),
        .pcbuf_q     (pcbuf_q),
        .pkt_d       (pkt_d),
        .pkt_vld     (pkt_vld),
        .pkt_rdy     (pkt_rdy),
        .pkt_sop     (pkt_sop),
        .pkt_eop     (pkt_eop),
        .pkt_busy    (pkt_busy),
        .pkt_cnt     (pkt_cnt)
    );

    always #5 clk_sys = ~clk_sys;

    assign pcbuf_empty = force_empty || (pushes == pops);
    assign pcbuf_full  = (pushes - pops) >= int'(chip_len[11:0]);

    // FIFO model: one-cycle read latency, level updates land after the DUT samples the edge.
    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (rst_n && pcbuf_rdreq && fifo.size() > 0) begin
            pcbuf_q   <= fifo.pop_front();
            pops      <= pops + 1;
            rd_issued <= rd_issued + 1;
        end
    end

    always @(negedge clk_sys) begin
        if (rst_n) begin
            if (prev_stall) begin
                checks++;
                if (pkt_vld !== 1'b1 || pkt_d !== prev_d) begin
                    errors++;
                    $display("FAIL hold got vld=%b d=%h want vld=1 d=%h", pkt_vld, pkt_d, prev_d);
                end
            end
            if (pkt_sop || pkt_eop) begin
                checks++;
                if (pkt_vld !== 1'b1) begin
                    errors++;
                    $display("FAIL qualifier got sop=%b eop=%b vld=%b want vld=1", pkt_sop, pkt_eop, pkt_vld);
                end
            end
            if (pkt_vld && pkt_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_word got %h want none", pkt_d);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (pkt_d !== mon_e.d || pkt_sop !== mon_e.sop || pkt_eop !== mon_e.eop) begin
                        errors++;
                        $display("FAIL word got %h sop=%b eop=%b want %h sop=%b eop=%b",
                                 pkt_d, pkt_sop, pkt_eop, mon_e.d, mon_e.sop, mon_e.eop);
                    end
                    if (mon_e.pay) pay_tx++;
                    if (mon_e.tag) last_tag = pkt_d;
                    if (mon_e.eop) eop_cyc = cyc;
                end
            end
            if (pkt_busy) begin
                checks++;
                if (rd_issued - pay_tx > 2) begin
                    errors++;
                    $display("FAIL outstanding got %0d want <=2", rd_issued - pay_tx);
                end
            end
            prev_stall = pkt_vld && !pkt_rdy;
            prev_d     = pkt_d;
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic start_pkt(input logic [6:0] s);
        logic [15:0] sum;
        logic [11:0] n;
        sum = 16'h0000;
        n   = 12'(pay_q.size());
        exp_q.push_back('{16'hEB90, 1'b1, 1'b0, 1'b0, 1'b0});
        exp_q.push_back('{{1'b0, s, exp_seq}, 1'b0, 1'b0, 1'b0, 1'b1});
        exp_q.push_back('{{4'h0, n}, 1'b0, 1'b0, 1'b0, 1'b0});
        foreach (pay_q[i]) begin
            exp_q.push_back('{pay_q[i], 1'b0, 1'b0, 1'b1, 1'b0});
            sum = sum + pay_q[i];
            fifo.push_back(pay_q[i]);
        end
        exp_q.push_back('{sum, 1'b0, 1'b1, 1'b0, 1'b0});
        pushes    = pushes + pay_q.size();
        exp_seq   = exp_seq + 8'd1;
        chip_len  = {8'h00, n};
        chip_sel  = s;
        pkt_en    = 1'b1;
        start_cyc = cyc;
    endtask

    task automatic run_until(input logic [15:0] target, input int budget, input bit rnd, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk_sys);
            #1;
            pkt_rdy = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            if (pkt_cnt == target && !pkt_busy) begin
                ok = 1'b1;
                break;
            end
        end
        pkt_rdy = 1'b1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        exp_q.delete();
        exp_seq = 8'd0;
        #1;
        pay_tx = rd_issued;
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        checks++; if (pkt_d !== 16'h0)    begin errors++; $display("FAIL reset_d got %h want 0000", pkt_d); end
        checks++; if (pkt_vld !== 1'b0)   begin errors++; $display("FAIL reset_vld got %b want 0", pkt_vld); end
        checks++; if (pkt_sop !== 1'b0)   begin errors++; $display("FAIL reset_sop got %b want 0", pkt_sop); end
        checks++; if (pkt_eop !== 1'b0)   begin errors++; $display("FAIL reset_eop got %b want 0", pkt_eop); end
        checks++; if (pkt_busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", pkt_busy); end
        checks++; if (pkt_cnt !== 16'h0)  begin errors++; $display("FAIL reset_cnt got %h want 0000", pkt_cnt); end
        checks++; if (pcbuf_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got %b want 0", pcbuf_rdreq); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        bit ok;
        int rd0;
        rd0 = rd_issued;
        pay_q.delete();
        pay_q.push_back(16'd1); pay_q.push_back(16'd2); pay_q.push_back(16'd3); pay_q.push_back(16'd4);
        start_pkt(7'd5);
        @(posedge clk_sys); #1;
        @(posedge clk_sys); #1;
        pkt_en = 1'b0;  // deasserting mid-packet must not abort it
        run_until(16'd1, 40, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL basic_done got cnt=%0d want 1", pkt_cnt); end
        checks++; if (eop_cyc - start_cyc != 10) begin errors++; $display("FAIL basic_sum_time got t+%0d want t+10", eop_cyc - start_cyc); end
        checks++; if (pkt_cnt !== 16'd1) begin errors++; $display("FAIL basic_cnt got %0d want 1", pkt_cnt); end
        checks++; if (rd_issued - rd0 != 4) begin errors++; $display("FAIL basic_rdreq got %0d want 4", rd_issued - rd0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL basic_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_backpressure();
        bit ok;
        int rd0;
        rd0 = rd_issued;
        pay_q.delete();
        pay_q.push_back(16'd1); pay_q.push_back(16'd2); pay_q.push_back(16'd3); pay_q.push_back(16'd4);
        start_pkt(7'd5);
        run_until(16'd2, 200, 1'b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL bp_done got cnt=%0d want 2", pkt_cnt); end
        checks++; if (rd_issued - rd0 != 4) begin errors++; $display("FAIL bp_rdreq got %0d want 4", rd_issued - rd0); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_len_zero();
        chip_len = 20'd0;
        pkt_en   = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk_sys); #1;
            checks++;
            if ({pkt_busy, pkt_vld, pcbuf_rdreq} !== 3'b000) begin
                errors++;
                $display("FAIL len_zero got busy=%b vld=%b rdreq=%b want 000", pkt_busy, pkt_vld, pcbuf_rdreq);
            end
        end
    endtask

    task automatic test_starvation();
        bit ok;
        bit seen_drop;
        seen_drop = 1'b0;
        pay_q.delete();
        pay_q.push_back(16'h0010); pay_q.push_back(16'h0020); pay_q.push_back(16'h0030); pay_q.push_back(16'h0040);
        start_pkt(7'd2);
        repeat (6) begin @(posedge clk_sys); #1; end
        force_empty = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (!pkt_vld && pkt_busy) seen_drop = 1'b1;
            @(posedge clk_sys); #1;
        end
        force_empty = 1'b0;
        run_until(16'd3, 40, 1'b0, ok);
        checks++; if (!seen_drop) begin errors++; $display("FAIL starve_drop got vld never low want a drop"); end
        checks++; if (!ok) begin errors++; $display("FAIL starve_done got cnt=%0d want 3", pkt_cnt); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL starve_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_seq_wrap();
        bit ok;
        do_reset();
        for (int i = 0; i < 257; i++) begin
            pay_q.delete();
            pay_q.push_back(16'hFFFF); pay_q.push_back(16'h0003);
            start_pkt(7'd1);
            run_until(16'(i + 1), 40, 1'b0, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL wrap_done got cnt=%0d want %0d", pkt_cnt, i + 1);
                break;
            end
        end
        checks++; if (pkt_cnt !== 16'd257) begin errors++; $display("FAIL wrap_cnt got %0d want 257", pkt_cnt); end
        checks++; if (last_tag !== 16'h0100) begin errors++; $display("FAIL wrap_tag got %h want 0100", last_tag); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL wrap_drain got %0d left want 0", exp_q.size()); end
    endtask

    task automatic test_reset_in_pay();
        bit ok;
        pay_q.delete();
        pay_q.push_back(16'd1); pay_q.push_back(16'd2); pay_q.push_back(16'd3); pay_q.push_back(16'd4);
        start_pkt(7'd3);
        repeat (8) begin @(posedge clk_sys); #1; end
        checks++; if (exp_q.size() != 3) begin errors++; $display("FAIL rip_progress got %0d left want 3", exp_q.size()); end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({pkt_d, pkt_vld, pkt_sop, pkt_eop, pkt_busy, pkt_cnt, pcbuf_rdreq} !== 37'd0) begin
            errors++;
            $display("FAIL rip_outputs got d=%h vld=%b busy=%b cnt=%0d rdreq=%b want all 0",
                     pkt_d, pkt_vld, pkt_busy, pkt_cnt, pcbuf_rdreq);
        end
        exp_q.delete();
        exp_seq = 8'd0;
        pay_tx  = rd_issued;
        repeat (2) @(posedge clk_sys);
        #1;
        rst_n = 1'b1;
        pay_q.delete();
        pay_q.push_back(16'd5); pay_q.push_back(16'd6); pay_q.push_back(16'd7);
        start_pkt(7'd9);
        run_until(16'd1, 40, 1'b0, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rip_done got cnt=%0d want 1", pkt_cnt); end
        checks++; if (last_tag !== 16'h0900) begin errors++; $display("FAIL rip_seq got %h want 0900", last_tag); end
        checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rip_drain got %0d left want 0", exp_q.size()); end
    endtask

    initial begin
        rst_n    = 1'b0;
        pkt_en   = 1'b0;
        chip_len = 20'd0;
        chip_sel = 7'd0;
        pkt_rdy  = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_len_zero();
        test_starvation();
        test_seq_wrap();
        test_reset_in_pay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
